// File: rtl/fft_pkg.sv
// Shared types and defaults for the radix-2 DIT FFT butterfly sequencer.
package fft_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } fft_state_e;

  localparam int unsigned DefLog2N   = 4;
  localparam int unsigned DefPipeLat = 3;

  // Width of a butterfly/twiddle index (N/2 entries); never narrower than one bit.
  function automatic int unsigned tw_width(int unsigned log2n);
    return (log2n > 1) ? log2n - 1 : 1;
  endfunction

endpackage

// File: rtl/fft_addr_delay.sv
// Depth-stage valid+payload shift register with async active-high reset; advances every cycle.
module fft_addr_delay #(
  parameter int unsigned Depth = 3,
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic [Depth-1:0]            valid_q;
  logic [Depth-1:0][Width-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q[0] <= valid_i;
      data_q[0]  <= data_i;
      for (int unsigned i = 1; i < Depth; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[Depth-1];
  assign data_o  = data_q[Depth-1];

endmodule

// File: rtl/fft_butterfly_sequencer.sv
// In-place radix-2 DIT FFT address sequencer: one butterfly per cycle, drain bubbles between
// stages. Optional macro FFT_SEQ_STALL_EN adds an i_stall input that pauses issue in RUN.
module fft_butterfly_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N    = DefLog2N,
  parameter int unsigned PIPE_LAT = DefPipeLat
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
`ifdef FFT_SEQ_STALL_EN
  input  logic                       i_stall,
`endif
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_rd_en,
  output logic [LOG2N-1:0]           o_rd_addr_a,
  output logic [LOG2N-1:0]           o_rd_addr_b,
  output logic [tw_width(LOG2N)-1:0] o_tw_addr,
  output logic                       o_wr_en,
  output logic [LOG2N-1:0]           o_wr_addr_a,
  output logic [LOG2N-1:0]           o_wr_addr_b,
  output logic [3:0]                 o_stage
);

  localparam int unsigned KW        = tw_width(LOG2N);
  localparam logic [KW-1:0] KLast   = KW'((1 << (LOG2N - 1)) - 1);
  localparam logic [3:0] StageLast  = 4'(LOG2N - 1);
  localparam logic [3:0] DrainLast  = 4'(PIPE_LAT - 1);

  fft_state_e       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [3:0]       stage_q, stage_d;
  logic [3:0]       drain_q, drain_d;
  logic             rd_en_q, busy_q, done_q;
  logic [LOG2N-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [KW-1:0]    tw_q, tw_d;
  logic [LOG2N-1:0] nxt_a, nxt_b;
  logic [KW-1:0]    nxt_tw;
  logic             issue;
  logic             stall;

`ifdef FFT_SEQ_STALL_EN
  assign stall = i_stall;
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    drain_d = drain_q;
    issue   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StRun;
          k_d     = '0;
          stage_d = '0;
          issue   = 1'b1;
        end
      end
      // Entering RUN always issues k_q, so each RUN cycle decides the *next* butterfly.
      StRun: begin
        if (!stall) begin
          if (k_q == KLast) begin
            state_d = StDrain;
            k_d     = '0;
            drain_d = '0;
          end else begin
            k_d   = k_q + KW'(1);
            issue = 1'b1;
          end
        end
      end
      StDrain: begin
        if (drain_q == DrainLast) begin
          drain_d = '0;
          if (stage_q == StageLast) begin
            state_d = StDone;
          end else begin
            stage_d = stage_q + 4'd1;
            state_d = StRun;
            issue   = 1'b1;
          end
        end else begin
          drain_d = drain_q + 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    int unsigned s, half, pos, kk, a;
    s      = int'(stage_d);
    kk     = int'(k_d);
    half   = 1 << s;
    pos    = kk & (half - 1);
    a      = ((kk >> s) << (s + 1)) | pos;
    nxt_a  = LOG2N'(a);
    nxt_b  = LOG2N'(a + half);
    nxt_tw = KW'(pos << (LOG2N - 1 - s));
  end

  // Addresses hold whenever nothing is issued (stall, drain, idle).
  assign addr_a_d = issue ? nxt_a : addr_a_q;
  assign addr_b_d = issue ? nxt_b : addr_b_q;
  assign tw_d     = issue ? nxt_tw : tw_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      k_q      <= '0;
      stage_q  <= '0;
      drain_q  <= '0;
      rd_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      stage_q  <= stage_d;
      drain_q  <= drain_d;
      rd_en_q  <= issue;
      busy_q   <= (state_d == StRun) || (state_d == StDrain);
      done_q   <= (state_d == StDone);
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      tw_q     <= tw_d;
    end
  end

  fft_addr_delay #(
    .Depth (PIPE_LAT),
    .Width (2 * LOG2N)
  ) u_wb_delay (
    .clk     (clk),
    .rst     (rst),
    .valid_i (rd_en_q),
    .data_i  ({addr_a_q, addr_b_q}),
    .valid_o (o_wr_en),
    .data_o  ({o_wr_addr_a, o_wr_addr_b})
  );

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_rd_en     = rd_en_q;
  assign o_rd_addr_a = addr_a_q;
  assign o_rd_addr_b = addr_b_q;
  assign o_tw_addr   = tw_q;
  assign o_stage     = stage_q;

endmodule
